// File: rtl/sparse_mem_if.sv
// Request/response bundle for the sparse associative memory.
// The requester drives the master side; the memory block sits on the slave side.
interface sparse_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int CW     = $clog2(DEPTH + 1)
);
  logic              clr;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_hit;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [CW-1:0]     count;
  logic              full;

  modport master (
    output clr, req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_hit, resp_err, resp_rdata, count, full
  );

  modport slave (
    input  clr, req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_hit, resp_err, resp_rdata, count, full
  );
endinterface

// File: rtl/sparse_mem.sv
// Sparse associative memory: a small table of (tag, data) pairs filled from
// index 0 upward. Each request walks the table one entry per cycle until it
// finds a matching tag or runs past the last valid entry, then answers with
// a one-cycle response strobe. Write misses append a new entry when room is
// left; otherwise the write is dropped and flagged with resp_err.
module sparse_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input logic        clk,
  input logic        rst,
  sparse_mem_if.slave bus
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  state_t            state;
  state_t            state_nxt;

  // Table storage; contents beyond count-1 are never looked at.
  logic [ADDR_W-1:0] tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // Request captured at the accepting edge.
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [CW-1:0]     count;
  logic [CW-1:0]     idx;
  logic              resp_valid;
  logic              resp_hit;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;

  logic              full;
  logic              accept;
  logic              in_range;
  logic              hit;
  logic              miss;
  logic [ADDR_W-1:0] tag_rd;
  logic [DATA_W-1:0] data_rd;

  assign full     = (count == CW'(DEPTH));
  assign accept   = (state == IDLE) && bus.req_valid;
  assign in_range = (idx < count);
  // idx only selects a real entry while in_range holds, so the truncation is safe.
  assign tag_rd   = tag_mem[idx[IW-1:0]];
  assign data_rd  = data_mem[idx[IW-1:0]];
  assign hit      = (state == SEARCH) && in_range && (tag_rd == addr_q);
  assign miss     = (state == SEARCH) && !in_range;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_hit   = resp_hit;
  assign bus.resp_err   = resp_err;
  assign bus.resp_rdata = resp_rdata;
  assign bus.count      = count;
  assign bus.full       = full;

  // State register; reset and clear both drop any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, scan in SEARCH, single-cycle RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = SEARCH;
      SEARCH:  if (hit || miss)   state_nxt = RESP;
      RESP:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
    if (bus.clr) state_nxt = IDLE;
  end

  // Capture the request on the accepting edge; held until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Scan index, entry count and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      idx        <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else if (bus.clr) begin
      count      <= '0;
      idx        <= '0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        idx <= '0;
      end else if (hit) begin
        resp_valid <= 1'b1;
        resp_hit   <= 1'b1;
        resp_err   <= 1'b0;
        resp_rdata <= we_q ? wdata_q : data_rd;
      end else if (miss) begin
        resp_valid <= 1'b1;
        resp_hit   <= 1'b0;
        if (we_q && !full) begin
          count      <= count + CW'(1);
          resp_err   <= 1'b0;
          resp_rdata <= wdata_q;
        end else begin
          resp_err   <= we_q;
          resp_rdata <= '0;
        end
      end else if (state == SEARCH) begin
        idx <= idx + CW'(1);
      end
    end
  end

  // Table writes happen only on the edge that resolves a write request.
  always_ff @(posedge clk) begin
    if (!bus.clr && hit && we_q) begin
      data_mem[idx[IW-1:0]] <= wdata_q;
    end
    if (!bus.clr && miss && we_q && !full) begin
      tag_mem[count[IW-1:0]]  <= addr_q;
      data_mem[count[IW-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_sparse_mem.sv
// Bench for sparse_mem with a 4-entry table. Each issued request pushes its
// expected response onto a scoreboard; a monitor pops and compares whenever
// the DUT raises resp_valid.
module tb_sparse_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic clk;
  logic rst;

  sparse_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CW(CW)) bus ();

  sparse_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        hit;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  int   acc_cyc;
  logic hold_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare every response against the oldest expectation.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_resp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("resp_hit",   bus.resp_hit,   e.hit);
        check_eq("resp_err",   bus.resp_err,   e.err);
        check_eq("resp_rdata", bus.resp_rdata, e.rdata);
        check_eq("latency",    cyc - e.acc,    e.lat);
      end
    end
  end

  // Present a request (called at a negedge) and wait for its accepting edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic acc;
    logic rdy;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      if (rdy) acc = 1'b1;
    end
    if (!acc) check_eq("accept_timeout", 0, 1);
    acc_cyc = cyc;
    if (!hold_valid) bus.req_valid = 1'b0;
  endtask

  // Wait for the response strobe; afterwards the block must be idle again.
  task automatic wait_resp();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
      else check_eq("busy_ready", bus.req_ready, 0);
    end
    if (!seen) begin
      check_eq("resp_timeout", 0, 1);
      sb.delete();
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("resp_one_cycle", bus.resp_valid, 0);
    check_eq("ready_after",    bus.req_ready,  1);
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic ehit, input logic eerr, input logic [31:0] erd, input int elat);
    exp_t e;
    issue(we, a, d);
    e.hit = ehit; e.err = eerr; e.rdata = erd; e.lat = elat; e.acc = acc_cyc;
    sb.push_back(e);
    wait_resp();
  endtask

  initial begin
    rst           = 1'b1;
    bus.clr       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #3;
    check_eq("rst_ready",  bus.req_ready,  1);
    check_eq("rst_valid",  bus.resp_valid, 0);
    check_eq("rst_hit",    bus.resp_hit,   0);
    check_eq("rst_err",    bus.resp_err,   0);
    check_eq("rst_rdata",  bus.resp_rdata, 0);
    check_eq("rst_count",  bus.count,      0);
    check_eq("rst_full",   bus.full,       0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Read miss on an empty table.
    txn(1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1);
    check_eq("empty_count", bus.count, 0);

    // Write miss then read hit.
    txn(1'b1, 32'h100, 32'hDEAD, 1'b0, 1'b0, 32'hDEAD, 1);
    check_eq("wr1_count", bus.count, 1);
    txn(1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'hDEAD, 1);

    // Overwrite via write hit; count must not grow.
    txn(1'b1, 32'h100, 32'h1, 1'b1, 1'b0, 32'h1, 1);
    txn(1'b1, 32'h100, 32'h2, 1'b1, 1'b0, 32'h2, 1);
    check_eq("ovw_count", bus.count, 1);
    txn(1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h2, 1);

    // Clear, then fill all four entries.
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check_eq("clr_count", bus.count, 0);
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0, 1'b0, 32'hA0 + 32'(i), i + 1);
    end
    check_eq("fill_count", bus.count, 4);
    check_eq("fill_full",  bus.full,  1);

    // Write miss on a full table is dropped.
    txn(1'b1, 32'h4, 32'hBEEF, 1'b0, 1'b1, 32'h0, 5);
    check_eq("err_count", bus.count, 4);
    check_eq("err_full",  bus.full,  1);

    // Hits at various depths, write hit on a full table, read miss.
    txn(1'b0, 32'h3, 32'h0, 1'b1, 1'b0, 32'hA3, 4);
    txn(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hA0, 1);
    txn(1'b1, 32'h2, 32'h77, 1'b1, 1'b0, 32'h77, 3);
    txn(1'b0, 32'h2, 32'h0, 1'b1, 1'b0, 32'h77, 3);
    txn(1'b0, 32'h9, 32'h0, 1'b0, 1'b0, 32'h0, 5);
    check_eq("miss_count", bus.count, 4);

    // Requester holds req_valid through the whole search: one response only.
    hold_valid = 1'b1;
    txn(1'b0, 32'h3, 32'h0, 1'b1, 1'b0, 32'hA3, 4);
    hold_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Clear mid-search: no response, table empty, ready next cycle.
    issue(1'b0, 32'h3, 32'h0);
    @(negedge clk);
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check_eq("clr_ready",  bus.req_ready,  1);
    check_eq("clr_cnt0",   bus.count,      0);
    check_eq("clr_nvalid", bus.resp_valid, 0);
    check_eq("clr_nfull",  bus.full,       0);
    repeat (6) @(negedge clk);
    txn(1'b0, 32'h3, 32'h0, 1'b0, 1'b0, 32'h0, 1);

    // Refill three entries, then async reset mid-search.
    for (int i = 0; i < 3; i++) begin
      txn(1'b1, 32'h10 + 32'(i), 32'h55 + 32'(i), 1'b0, 1'b0, 32'h55 + 32'(i), i + 1);
    end
    check_eq("refill_count", bus.count, 3);
    issue(1'b0, 32'h12, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", bus.resp_valid, 0);
    check_eq("arst_hit",   bus.resp_hit,   0);
    check_eq("arst_err",   bus.resp_err,   0);
    check_eq("arst_rdata", bus.resp_rdata, 0);
    check_eq("arst_count", bus.count,      0);
    check_eq("arst_ready", bus.req_ready,  1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    txn(1'b0, 32'h12, 32'h0, 1'b0, 1'b0, 32'h0, 1);
    check_eq("post_rst_count", bus.count, 0);

    if (sb.size() != 0) check_eq("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sparse_mem.md
SPARSE_MEM -- requirements
Module: sparse_mem

Interface
REQ-001 Parameter DATA_W, default 32, sets the width of stored data words.
REQ-002 Parameter ADDR_W, default 32, sets the width of stored address tags.
REQ-003 Parameter DEPTH, default 64, sets the number of (address, data) entries; minimum 2.
REQ-004 Parameter CW = $clog2(DEPTH+1) sets the width of count.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port clr, input, 1: synchronous clear of all entries.
REQ-008 Port req_valid, input, 1: request present.
REQ-009 Port req_ready, output, 1: block can accept a request.
REQ-010 Port req_we, input, 1: 1 = write, 0 = read.
REQ-011 Port req_addr, input, ADDR_W: address tag.
REQ-012 Port req_wdata, input, DATA_W: write data.
REQ-013 Port resp_valid, output, 1: one-cycle response strobe.
REQ-014 Port resp_hit, output, 1: address matched an existing entry.
REQ-015 Port resp_err, output, 1: write miss dropped because the table was full.
REQ-016 Port resp_rdata, output, DATA_W: read data.
REQ-017 Port count, output, CW: number of valid entries.
REQ-018 Port full, output, 1: count == DEPTH.

Function
REQ-019 The block SHALL hold entries 0..count-1 as (tag, data) pairs, filled contiguously from index 0.
REQ-020 The FSM SHALL have the states IDLE, SEARCH and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Accept: when req_valid=1 and req_ready=1 at an edge, the block SHALL register req_we, req_addr and req_wdata, set idx=0 and move to SEARCH.
REQ-022 Requests presented while req_ready=0 SHALL be ignored; the requester holds req_valid.
REQ-023 In SEARCH with idx<count and tag[idx]==addr, the block SHALL resolve a hit.
- Read hit: capture data[idx] into resp_rdata.
- Write hit: overwrite data[idx] with wdata; resp_rdata = wdata.
- Then move to RESP with resp_hit=1.
REQ-024 In SEARCH with idx<count and no match, the block SHALL increment idx and stay in SEARCH.
REQ-025 In SEARCH with idx==count, the block SHALL resolve a miss and move to RESP with resp_hit=0.
- Read miss: resp_rdata=0.
- Write miss, not full: write tag[count]=addr and data[count]=wdata, increment count, resp_rdata=wdata.
- Write miss, full: store nothing, resp_err=1, resp_rdata=0.
REQ-026 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-027 Latency: a hit at index k SHALL raise resp_valid k+1 edges after the accepting edge; a miss with count=n SHALL raise it n+1 edges after.
REQ-028 resp_hit, resp_err and resp_rdata SHALL be valid only while resp_valid=1; they hold their values otherwise.
REQ-029 Duplicate tags SHALL never exist; the lowest-index match SHALL win regardless.
REQ-030 Writes to the table SHALL occur only on the resolving SEARCH edge.
REQ-031 When clr=1 at an edge, in any state, the block SHALL set count=0, go to IDLE and produce no response for an in-flight request; clr has priority over all other events.
REQ-032 full SHALL be combinational from count; count SHALL never exceed DEPTH.

Reset
REQ-033 While rst=1, independent of clk, the block SHALL force state=IDLE, count=0, idx=0, resp_valid=0, resp_hit=0, resp_err=0 and resp_rdata=0.
REQ-034 Table contents SHALL be left unreset; they are unreachable because count=0.
REQ-035 A reset during SEARCH or RESP SHALL abort the request with no response.

Verification
REQ-036 Reset, then read 0x100 -> resp_valid 1 edge after accept, resp_hit=0, resp_rdata=0, count=0.
REQ-037 Write 0x100/0xDEAD, then read 0x100 -> write: hit=0, count=1; read: hit=1, rdata=0xDEAD, latency 1 edge.
REQ-038 Write 0x100/0x1 then 0x100/0x2, then read -> second write hit=1, count stays 1, read returns 0x2.
REQ-039 DEPTH=4: fill tags 0..3, then write tag 4 -> resp_err=1, full=1, count=4; read tag 3 latency 4 edges, rdata correct.
REQ-040 Hold req_valid during SEARCH -> no second accept until IDLE; pulse clr mid-SEARCH -> no resp_valid, count=0, req_ready=1 next cycle.
REQ-041 Assert rst asynchronously mid-SEARCH -> outputs zero immediately, count=0, subsequent read misses.
